// File: rtl/datastore_ctrl.sv
// Sequences PS/2 scan bytes into the 28-byte message datastore: release filtering, backspace,
// input-full, Enter completion with ack handshake. Optional zero-fill on start: DATASTORE_CLEAR_EN.
module datastore_ctrl #(
  parameter int                 DEPTH      = 28,
  parameter int                 IDX_W      = 5,
  parameter int                 DATA_W     = 8,
  parameter logic [DATA_W-1:0]  BREAK_CODE = 8'hF0,
  parameter logic [DATA_W-1:0]  EXT_CODE   = 8'hE0,
  parameter logic [DATA_W-1:0]  ENTER_CODE = 8'h5A,
  parameter logic [DATA_W-1:0]  BKSP_CODE  = 8'h66
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ps2_byte,
  input  logic              ps2_valid,
  input  logic              start,
  input  logic              msg_ack,
  output logic [IDX_W-1:0]  wr_index,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic [IDX_W:0]    count,
  output logic              full,
  output logic              busy,
  output logic              msg_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_BREAK,
    S_DONE
`ifdef DATASTORE_CLEAR_EN
    , S_CLEAR
`endif
  } state_t;

  localparam logic [IDX_W:0]   DEPTH_CNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   CNT_ONE   = (IDX_W+1)'(1);

`ifdef DATASTORE_CLEAR_EN
  localparam state_t           START_DEST = S_CLEAR;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
`else
  localparam state_t           START_DEST = S_CAPTURE;
`endif

  state_t              state, state_n;
  logic [IDX_W:0]      count_n, count_dec;
  logic [IDX_W-1:0]    wr_index_n;
  logic [DATA_W-1:0]   wr_data_n;
  logic                wr_en_n, msg_done_n, full_n, busy_n;
`ifdef DATASTORE_CLEAR_EN
  logic [IDX_W-1:0]    clr_idx, clr_idx_n;
`endif

  assign count_dec = count - CNT_ONE;

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n    = state;
    count_n    = count;
    wr_en_n    = 1'b0;
    wr_index_n = wr_index;
    wr_data_n  = wr_data;
    msg_done_n = msg_done;
`ifdef DATASTORE_CLEAR_EN
    clr_idx_n  = clr_idx;
`endif

    unique case (state)
      S_IDLE: begin
        if (start) begin
          count_n = '0;
          state_n = START_DEST;
`ifdef DATASTORE_CLEAR_EN
          clr_idx_n = '0;
`endif
        end
      end

      S_CAPTURE, S_BREAK: begin
        // start outranks a simultaneous byte, which is simply dropped
        if (start) begin
          count_n = '0;
          state_n = START_DEST;
`ifdef DATASTORE_CLEAR_EN
          clr_idx_n = '0;
`endif
        end else if (ps2_valid) begin
          if (state == S_BREAK) begin
            state_n = S_CAPTURE;
          end else if (ps2_byte == BREAK_CODE) begin
            state_n = S_BREAK;
          end else if (ps2_byte == EXT_CODE) begin
            state_n = S_CAPTURE;
          end else if (ps2_byte == ENTER_CODE) begin
            msg_done_n = 1'b1;
            state_n    = S_DONE;
          end else if (ps2_byte == BKSP_CODE) begin
            if (count != '0) begin
              wr_en_n    = 1'b1;
              wr_index_n = count_dec[IDX_W-1:0];
              wr_data_n  = '0;
              count_n    = count_dec;
            end
          end else if (count < DEPTH_CNT) begin
            wr_en_n    = 1'b1;
            wr_index_n = count[IDX_W-1:0];
            wr_data_n  = ps2_byte;
            count_n    = count + CNT_ONE;
          end
        end
      end

      S_DONE: begin
        if (msg_ack) begin
          msg_done_n = 1'b0;
          state_n    = S_IDLE;
        end
      end

`ifdef DATASTORE_CLEAR_EN
      S_CLEAR: begin
        wr_en_n    = 1'b1;
        wr_index_n = clr_idx;
        wr_data_n  = '0;
        if (clr_idx == LAST_IDX) begin
          count_n = '0;
          state_n = S_CAPTURE;
        end else begin
          clr_idx_n = clr_idx + IDX_ONE;
        end
      end
`endif

      default: state_n = S_IDLE;
    endcase

    // busy and full are registered alongside the state/count they describe
    busy_n = (state_n != S_IDLE) && (state_n != S_DONE);
    full_n = (count_n == DEPTH_CNT);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      wr_en    <= 1'b0;
      wr_index <= '0;
      wr_data  <= '0;
      msg_done <= 1'b0;
      full     <= 1'b0;
      busy     <= 1'b0;
`ifdef DATASTORE_CLEAR_EN
      clr_idx  <= '0;
`endif
    end else begin
      state    <= state_n;
      count    <= count_n;
      wr_en    <= wr_en_n;
      wr_index <= wr_index_n;
      wr_data  <= wr_data_n;
      msg_done <= msg_done_n;
      full     <= full_n;
      busy     <= busy_n;
`ifdef DATASTORE_CLEAR_EN
      clr_idx  <= clr_idx_n;
`endif
    end
  end

endmodule
